// File: rtl/mac_seq.sv
// Operand sequencer for a MAC: clears the accumulator, streams stored A/B pairs one per
// cycle, then captures the MAC sum as the dot-product result and pulses done.
module mac_seq #(
  parameter int iwidth = 4,
  parameter int swidth = 10,
  parameter int depth  = 8,
  localparam int aw = $clog2(depth),
  localparam int lw = $clog2(depth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [aw-1:0]     wr_addr,
  input  logic [iwidth-1:0] wr_a,
  input  logic [iwidth-1:0] wr_b,
  input  logic              start,
  input  logic [lw-1:0]     len,
  output logic              busy,
  output logic              done,
  output logic [swidth-1:0] result_o,
  output logic [iwidth-1:0] a_o,
  output logic [iwidth-1:0] b_o,
  output logic              mac_rst_n,
  input  logic [swidth-1:0] sum_i
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  localparam logic [lw-1:0] DEPTH_L = lw'(depth);

  state_t            r_state;
  logic [lw-1:0]     r_len;
  logic [lw-1:0]     r_idx;
  logic              r_busy;
  logic              r_done;
  logic [swidth-1:0] r_result;
  logic [iwidth-1:0] r_a;
  logic [iwidth-1:0] r_b;
  logic              r_mac_rst_n;
  logic [iwidth-1:0] r_mem_a [depth];
  logic [iwidth-1:0] r_mem_b [depth];

  logic [lw-1:0]     w_len_clamped;
  logic              w_wr_ok;

  assign w_len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_wr_ok       = wr_en && (r_state == IDLE) && (lw'(wr_addr) < DEPTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        r_mem_a[i] <= '0;
        r_mem_b[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem_a[wr_addr] <= wr_a;
      r_mem_b[wr_addr] <= wr_b;
    end
  end

  // MAC sees pair k one edge after we drive it, so the sum is final only in DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mac_rst_n <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_a         <= '0;
          r_b         <= '0;
          r_mac_rst_n <= 1'b1;
          if (start) begin
            r_len       <= w_len_clamped;
            r_mac_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= CLEAR;
          end
        end
        CLEAR: begin
          r_mac_rst_n <= 1'b1;
          r_idx       <= '0;
          if (r_len == '0) begin
            r_state <= DRAIN;
          end else begin
            r_a     <= r_mem_a[0];
            r_b     <= r_mem_b[0];
            r_idx   <= lw'(1);
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_idx < r_len) begin
            r_a   <= r_mem_a[r_idx[aw-1:0]];
            r_b   <= r_mem_b[r_idx[aw-1:0]];
            r_idx <= r_idx + lw'(1);
          end else begin
            r_a     <= '0;
            r_b     <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_result <= sum_i;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result_o  = r_result;
  assign a_o       = r_a;
  assign b_o       = r_b;
  assign mac_rst_n = r_mac_rst_n;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: behavioural MAC plus a timeline model of the sequencer, checked every cycle.
module tb_mac_seq;
  localparam int IW = 4, SW = 10, DEPTH = 8, AW = 3, LW = 4;

  logic          clk, rst, wr_en, start;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_a, wr_b;
  logic [LW-1:0] len;
  logic          busy, done, mac_rst_n;
  logic [SW-1:0] result_o, mac_sum;
  logic [IW-1:0] a_o, b_o;

  int errors = 0, checks = 0, cyc = 0, e0 = 0;
  bit chk_en = 0;

  mac_seq #(.iwidth(IW), .swidth(SW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .len(len), .busy(busy), .done(done), .result_o(result_o),
    .a_o(a_o), .b_o(b_o), .mac_rst_n(mac_rst_n), .sum_i(mac_sum)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: async clear on low rstn, accumulates a*b every edge otherwise.
  always @(posedge clk or negedge mac_rst_n)
    if (!mac_rst_n) mac_sum <= '0;
    else            mac_sum <= mac_sum + SW'(a_o) * SW'(b_o);

  // Reference model: edge count since the accepted start defines every output.
  int  m_mem_a [DEPTH];
  int  m_mem_b [DEPTH];
  bit  m_active;
  int  m_t, m_len;
  int  exp_busy, exp_done, exp_res, exp_a, exp_b, exp_mrn;

  function automatic int dot(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += m_mem_a[k] * m_mem_b[k];
    return s % (1 << SW);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_t <= 0; m_len <= 0;
      exp_busy <= 0; exp_done <= 0; exp_res <= 0; exp_a <= 0; exp_b <= 0; exp_mrn <= 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem_a[i] <= 0;
        m_mem_b[i] <= 0;
      end
    end else if (!m_active) begin
      exp_done <= 0; exp_a <= 0; exp_b <= 0;
      if (wr_en && int'(wr_addr) < DEPTH) begin
        m_mem_a[wr_addr] <= int'(wr_a);
        m_mem_b[wr_addr] <= int'(wr_b);
      end
      if (start) begin
        m_active <= 1; m_t <= 0;
        m_len    <= (int'(len) > DEPTH) ? DEPTH : int'(len);
        exp_busy <= 1; exp_mrn <= 0;
      end else begin
        exp_busy <= 0; exp_mrn <= 1;
      end
    end else begin
      exp_mrn  <= 1;
      exp_done <= 0;
      if (m_t + 1 <= m_len) begin
        exp_a <= m_mem_a[m_t];
        exp_b <= m_mem_b[m_t];
      end else begin
        exp_a <= 0;
        exp_b <= 0;
      end
      if (m_t + 1 == m_len + 2) begin
        exp_done <= 1; exp_res <= dot(m_len); exp_busy <= 0; m_active <= 0;
      end
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("busy",      32'(busy),      32'(exp_busy));
    chk("done",      32'(done),      32'(exp_done));
    chk("result_o",  32'(result_o),  32'(exp_res));
    chk("a_o",       32'(a_o),       32'(exp_a));
    chk("b_o",       32'(b_o),       32'(exp_b));
    chk("mac_rst_n", 32'(mac_rst_n), 32'(exp_mrn));
  end

  task automatic wr(input int addr, input int a, input int b);
    wr_en = 1; wr_addr = AW'(addr); wr_a = IW'(a); wr_b = IW'(b);
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic start_run(input int l);
    start = 1; len = LW'(l);
    @(posedge clk); #1;
    start = 0; e0 = cyc;
  endtask

  task automatic wait_done(input string name, input int res, input int lat);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_latency"}, 32'(cyc - e0), 32'(lat));
      chk({name, "_result"},  32'(result_o), 32'(res));
      chk({name, "_busy"},    32'(busy),     32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; wr_en = 0; wr_addr = '0; wr_a = '0; wr_b = '0; start = 0; len = '0;
    #1 rst = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result_o), 0);
    chk("rst_mac_rst_n", 32'(mac_rst_n), 0);
    rst = 0;
    @(negedge clk);
    chk("mac_rst_n_after_release", 32'(mac_rst_n), 1);

    // 1..4 dot 1..4 = 30
    for (int i = 0; i < 4; i++) wr(i, i + 1, i + 1);
    start_run(4);
    wait_done("dot4", 30, 6);

    // 8 x 225 = 1800, wraps to 776
    for (int i = 0; i < 8; i++) wr(i, 15, 15);
    start_run(8);
    wait_done("wrap8", 776, 10);

    // empty vector
    start_run(0);
    chk("len0_clear_low", 32'(mac_rst_n), 0);
    @(posedge clk); #1;
    chk("len0_clear_high", 32'(mac_rst_n), 1);
    chk("len0_a_o", 32'(a_o), 0);
    wait_done("len0", 0, 2);

    // start and write during RUN are ignored
    for (int i = 0; i < 4; i++) wr(i, i + 1, i + 1);
    start_run(4);
    @(posedge clk); #1;
    start = 1; wr_en = 1; wr_addr = '0; wr_a = 4'd9; wr_b = 4'd9;
    @(posedge clk); #1;
    start = 0; wr_en = 0;
    wait_done("busy_ignore", 30, 6);
    start_run(4);
    wait_done("rerun", 30, 6);

    // reset mid-RUN clears storage and outputs
    start_run(4);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mac_rst_n", 32'(mac_rst_n), 0);
    chk("midrst_a_o", 32'(a_o), 0);
    chk("midrst_result", 32'(result_o), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    start_run(3);
    wait_done("after_rst", 0, 5);

    // start held high: back-to-back runs, 2*4 + 3*5 = 23
    wr(0, 2, 4); wr(1, 3, 5);
    start = 1; len = LW'(2);
    @(posedge clk); #1;
    e0 = cyc;
    wait_done("b2b_first", 23, 4);
    wait_done("b2b_second", 23, 9);
    start = 0;

    // len above depth clamps to depth; entries 2..7 are zero after reset
    @(negedge clk);
    start_run(12);
    wait_done("clamp", 23, 10);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_seq.md
# mac_seq

Operand sequencer that sits directly upstream of the multiply-accumulate unit and closes the loop on its result. It holds two small operand vectors written by the host. On `start` it clears the MAC accumulator, then streams one operand pair per cycle into the MAC's `a_i`/`b_i` inputs. When the last product has been accumulated it captures the MAC `sum_o` as a dot-product result and pulses `done`.

## Interface
Parameters:
- `iwidth`, 4: operand width; must match the MAC's `iwidth`.
- `swidth`, 10: accumulator/result width; must match the MAC's `swidth`.
- `depth`, 8: vector storage entries. `aw = $clog2(depth)`, `lw = $clog2(depth+1)`.

Ports:
- `clk` in 1: single clock, rising edge; the MAC uses the same clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write one operand pair.
- `wr_addr` in aw: entry index for the write.
- `wr_a` in iwidth: A-vector value.
- `wr_b` in iwidth: B-vector value.
- `start` in 1: level, sampled on clock edges; begins a dot product.
- `len` in lw: number of pairs, 0..depth, latched with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `result_o` is updated.
- `result_o` out swidth: last captured dot product.
- `a_o` out iwidth: drives MAC `a_i`.
- `b_o` out iwidth: drives MAC `b_i`.
- `mac_rst_n` out 1: drives MAC `rstn`; registered, low for one cycle to clear the accumulator.
- `sum_i` in swidth: from MAC `sum_o`.

## Operation
- Storage: two register arrays `mem_a` and `mem_b`, each depth x iwidth.
  - `wr_en` writes both arrays at `wr_addr`, only in IDLE. Writes while `busy` are ignored.
  - A `wr_addr` ≥ depth is ignored.
- States: IDLE, CLEAR, RUN, DRAIN. All outputs are registered.
- IDLE
  - `a_o` = `b_o` = 0, so the MAC holds its value. `mac_rst_n` = 1.
  - If `start` is high: latch `len` (values > depth clamp to depth), set `mac_rst_n` <= 0 and go to CLEAR.
- CLEAR
  - `mac_rst_n` <= 1, `idx` <= 0.
  - If `len` == 0, go to DRAIN.
  - Otherwise `a_o` <= `mem_a[0]`, `b_o` <= `mem_b[0]`, `idx` <= 1, and go to RUN.
- RUN
  - If `idx` < `len`: `a_o`/`b_o` <= `mem[idx]`, `idx`++.
  - Otherwise: `a_o` = `b_o` <= 0 and go to DRAIN.
- DRAIN
  - `result_o` <= `sum_i`, `done` <= 1, go to IDLE.
- Arithmetic is done in the MAC.
  - Result = Σ A[k]·B[k] for k < len, modulo 2^swidth. Wrap-around is silent, with no overflow flag.
  - `len` = 0 gives result 0.
- `start` while `busy` is ignored. `start` held high re-triggers from IDLE, which gives back-to-back runs.
- Reset mid-operation: state returns to IDLE, storage is cleared, and all outputs take their reset values. Because `mac_rst_n` = 0, the MAC is cleared as well.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `result_o` = 0, `a_o` = `b_o` = 0.
  - `mac_rst_n` = 0; it goes to 1 on the first edge after `rst` is released.
  - `mem_a` = `mem_b` = 0, `idx` = 0, state = IDLE.
- Let E0 be the edge that samples `start` in IDLE.
  - After E0: CLEAR, `busy` = 1, MAC cleared asynchronously.
  - Edge E(k+1) drives pair k, for k = 0..len-1. The MAC accumulates pair k at E(k+2).
  - At E(len+1): state DRAIN, `a_o` = `b_o` = 0. `sum_i` now holds the final value.
  - At E(len+2): `result_o` is updated and `done` = 1 for one cycle. State is IDLE, `busy` = 0.
- Latency from the `start` edge to the `done` cycle is len+2 edges, including `len` = 0.
- Throughput is one pair per cycle. Between back-to-back runs, `start` is accepted on the edge after the `done` edge.
- `result_o` holds its value until the next `done`.

## Test plan
- Load A = B = {1,2,3,4}, start with `len` = 4. Required: `result_o` = 30, with `done` at E6 and `busy` low in the same cycle.
- Load all 8 entries with 15/15, `len` = 8. Required: `result_o` = 1800 mod 1024 = 776 (wrap), `done` at E10.
- `len` = 0. Required: `mac_rst_n` is low for one cycle, `a_o` stays 0, `result_o` = 0, `done` at E2.
- During RUN with `len` = 4, pulse `start` and write `wr_a` = 9 to addr 0. Required: both are ignored, the result is still 30, and a rerun also gives 30.
- Assert `rst` mid-RUN (after E2), release it, then start with `len` = 3. Required: outputs are at reset values while `rst` is high, storage is zeroed, and `result_o` = 0 at E5.
- Hold `start` high with `len` = 2 and A = {2,3}, B = {4,5}. Required: `done` with 23 at E4, the next start is accepted at E5, and `done` with 23 again at E9.
